// File: rtl/mem_pkg.sv
// Shared constants, access-size encodings and FSM state type for the main memory block.
package mem_pkg;

  localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;
  localparam int unsigned MEM_DEPTH      = 32'd1048576;

  typedef enum logic [1:0] {
    ACC_1W  = 2'b00,
    ACC_4W  = 2'b01,
    ACC_8W  = 2'b10,
    ACC_16W = 2'b11
  } acc_size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  function automatic logic [4:0] burst_len(input logic [1:0] acc);
    logic [4:0] len;
    case (acc)
      ACC_1W:  len = 5'd1;
      ACC_4W:  len = 5'd4;
      ACC_8W:  len = 5'd8;
      ACC_16W: len = 5'd16;
      default: len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/memory_if.sv
// Request/response bundle between a bus master and the main memory.
interface memory_if #(
  parameter int data_width    = 32,
  parameter int address_width = 32
);
  logic [address_width-1:0] address;
  logic [data_width-1:0]    data_in;
  logic [data_width-1:0]    data_out;
  logic [1:0]               access_size;
  logic                     rw;
  logic                     enable;
  logic                     busy;

  modport master (output address, data_in, access_size, rw, enable,
                  input  busy, data_out);
  modport slave  (input  address, data_in, access_size, rw, enable,
                  output busy, data_out);
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: accepts requests, latches rw/base address of a burst and
// presents the address and direction of the beat performed on each edge.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int address_width = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     rw,
  input  logic [1:0]               access_size,
  input  logic [address_width-1:0] address,
  output logic                     busy,
  output logic                     beat_valid,
  output logic                     beat_rw,
  output logic [address_width-1:0] beat_addr
);

  burst_state_e             state_r, state_next_s;
  logic [4:0]               beats_left_r;
  logic [address_width-1:0] burst_addr_r;
  logic                     rw_r;
  logic [address_width-1:0] aligned_s;
  logic [4:0]               len_s;
  logic                     start_burst_s;

  assign aligned_s     = address & {{(address_width-2){1'b1}}, 2'b00};
  assign len_s         = burst_len(access_size);
  assign start_burst_s = (state_r == ST_IDLE) && enable && (access_size != ACC_1W);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Beat counter and latched burst context; burst_addr_r always points at the next beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beats_left_r <= 5'd0;
      burst_addr_r <= {address_width{1'b0}};
      rw_r         <= 1'b0;
    end else if (start_burst_s) begin
      beats_left_r <= len_s - 5'd1;
      burst_addr_r <= aligned_s + {{(address_width-3){1'b0}}, 3'd4};
      rw_r         <= rw;
    end else if (state_r == ST_BURST) begin
      beats_left_r <= beats_left_r - 5'd1;
      burst_addr_r <= burst_addr_r + {{(address_width-3){1'b0}}, 3'd4};
    end
  end

  // Next-state logic: leave BURST on the edge that performs the final beat
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = start_burst_s ? ST_BURST : ST_IDLE;
      ST_BURST: state_next_s = (beats_left_r == 5'd1) ? ST_IDLE : ST_BURST;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Beat selection: live request when idle, latched burst context otherwise
  always_comb begin
    beat_valid = 1'b0;
    beat_rw    = 1'b0;
    beat_addr  = {address_width{1'b0}};
    case (state_r)
      ST_IDLE: begin
        beat_valid = enable;
        beat_rw    = rw;
        beat_addr  = aligned_s;
      end
      ST_BURST: begin
        beat_valid = 1'b1;
        beat_rw    = rw_r;
        beat_addr  = burst_addr_r;
      end
      default: begin
        beat_valid = 1'b0;
        beat_rw    = 1'b0;
        beat_addr  = {address_width{1'b0}};
      end
    endcase
  end

  assign busy = (state_r == ST_BURST);

endmodule

// File: rtl/memory.sv
// Main memory: big-endian byte storage with range check and registered read data,
// driven one beat per clock by the burst sequencer.
module memory
  import mem_pkg::*;
#(
  parameter int                          data_width    = 32,
  parameter int                          address_width = 32,
  parameter int unsigned                 depth         = MEM_DEPTH,
  parameter logic [address_width-1:0]    start_addr    = MEM_START_ADDR
) (
  input  logic     clock,
  input  logic     reset_n,
  memory_if.slave  bus
);

  localparam int                       IDX_W    = $clog2(depth);
  localparam logic [address_width-1:0] LAST_OFF = address_width'(depth - 32'd4);

  logic [7:0]               mem [depth];
  logic                     busy_s, beat_valid_s, beat_rw_s;
  logic [address_width-1:0] beat_addr_s, offset_s;
  logic [IDX_W-1:0]         idx_s;
  logic                     in_range_s, write_s, read_s;
  logic [data_width-1:0]    rd_word_s, data_out_r;

  mem_burst_ctrl #(.address_width(address_width)) u_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (bus.enable),
    .rw          (bus.rw),
    .access_size (bus.access_size),
    .address     (bus.address),
    .busy        (busy_s),
    .beat_valid  (beat_valid_s),
    .beat_rw     (beat_rw_s),
    .beat_addr   (beat_addr_s)
  );

  // Addresses below start_addr wrap to huge offsets and fail the same check
  assign offset_s   = beat_addr_s - start_addr;
  assign in_range_s = (offset_s <= LAST_OFF);
  assign idx_s      = offset_s[IDX_W-1:0];
  assign write_s    = beat_valid_s && !beat_rw_s && in_range_s;
  assign read_s     = beat_valid_s && beat_rw_s;

  assign rd_word_s = {mem[idx_s],
                      mem[idx_s + IDX_W'(1)],
                      mem[idx_s + IDX_W'(2)],
                      mem[idx_s + IDX_W'(3)]};

  // Storage write port; contents survive reset
  always_ff @(posedge clock) begin
    if (write_s) begin
      mem[idx_s]             <= bus.data_in[31:24];
      mem[idx_s + IDX_W'(1)] <= bus.data_in[23:16];
      mem[idx_s + IDX_W'(2)] <= bus.data_in[15:8];
      mem[idx_s + IDX_W'(3)] <= bus.data_in[7:0];
    end
  end

  // Read data register, holds between reads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= {data_width{1'b0}};
    end else if (read_s) begin
      data_out_r <= in_range_s ? rd_word_s : {data_width{1'b0}};
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.busy     = busy_s;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: vector table for single accesses plus
// hand-written burst and reset sequences, expectations queued per driven cycle.
module tb_memory;

  logic clk;
  logic rst_n;

  memory_if bus ();

  memory dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] din;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        exp_busy;
  } vec_t;

  typedef struct {
    logic        chk_d;
    logic [31:0] exp_d;
    logic        exp_busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus; expectation is queued at drive time and checked after the edge
  task automatic cycle(input logic en, input logic rw, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] din,
                       input logic chk_d, input logic [31:0] exp_d,
                       input logic exp_busy, input string name);
    exp_t e;
    @(negedge clk);
    bus.enable      = en;
    bus.rw          = rw;
    bus.access_size = sz;
    bus.address     = addr;
    bus.data_in     = din;
    exp_q.push_back('{chk_d, exp_d, exp_busy});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, ".busy"}, {31'd0, bus.busy}, {31'd0, e.exp_busy});
      if (e.chk_d) check({name, ".data"}, bus.data_out, e.exp_d);
    end
  endtask

  vec_t tbl[16];

  initial begin
    clk             = 1'b0;
    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.rw          = 1'b0;
    bus.access_size = 2'b00;
    bus.address     = 32'h0;
    bus.data_in     = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, bus.busy}, 32'd0);
    check("reset.data", bus.data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //           en    rw    sz     addr           din            chk   exp_d          busy
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 32'h8002_0000, 32'h27BD_FFF8, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 32'h8002_0004, 32'hAFBF_0004, 1'b0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 32'h8002_0008, 32'h0000_0000, 1'b0, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'b00, 32'h8002_0000, 32'h0,         1'b1, 32'h27BD_FFF8, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'b00, 32'h8002_0004, 32'h0,         1'b1, 32'hAFBF_0004, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2'b00, 32'h8002_0008, 32'h0,         1'b1, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 32'h8002_0010, 32'h1122_3344, 1'b0, 32'h0,         1'b0};
    tbl[7]  = '{1'b1, 1'b1, 2'b00, 32'h8002_0012, 32'h0,         1'b1, 32'h1122_3344, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'b00, 32'h8002_0000, 32'h0,         1'b1, 32'h1122_3344, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'b00, 32'h8012_0000, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'b00, 32'h8012_0000, 32'h0,         1'b1, 32'h0,         1'b0};
    tbl[11] = '{1'b1, 1'b1, 2'b00, 32'h8002_0000, 32'h0,         1'b1, 32'h27BD_FFF8, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 2'b00, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'b00, 32'h8011_FFFC, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0};
    tbl[14] = '{1'b1, 1'b1, 2'b00, 32'h8011_FFFC, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 2'b00, 32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0,         1'b0};

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].en, tbl[i].rw, tbl[i].sz, tbl[i].addr, tbl[i].din,
            tbl[i].chk_d, tbl[i].exp_d, tbl[i].exp_busy, $sformatf("vec%0d", i));
    end
    check("endian.byte0", {24'd0, dut.mem[16]}, 32'h11);
    check("endian.byte3", {24'd0, dut.mem[19]}, 32'h44);

    // Burst read with junk on the request inputs while busy
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 1'b0, 2'b00, 32'h8002_0000 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0, 32'h0, 1'b0, "bpre");
    cycle(1'b1, 1'b0, 2'b00, 32'h8002_0040, 32'h1234_5678, 1'b0, 32'h0, 1'b0, "bpre_guard");
    cycle(1'b1, 1'b1, 2'b01, 32'h8002_0000, 32'h0, 1'b1, 32'hA0, 1'b1, "bread0");
    for (int k = 1; k < 4; k++)
      cycle(k[0], 1'b0, 2'b11, 32'h8002_0040, 32'hFFFF_FFFF, 1'b1, 32'hA0 + 32'(k),
            (k != 3), $sformatf("bread%0d", k));
    cycle(1'b1, 1'b1, 2'b00, 32'h8002_0040, 32'h0, 1'b1, 32'h1234_5678, 1'b0, "bread_guard");
    cycle(1'b1, 1'b1, 2'b00, 32'h8002_000C, 32'h0, 1'b1, 32'hA3, 1'b0, "bread_after");

    // 16-beat write burst aborted by reset after beat 5
    for (int k = 0; k < 16; k++)
      cycle(1'b1, 1'b0, 2'b00, 32'h8002_0100 + 32'(4 * k), 32'h5000_0000 + 32'(k),
            1'b0, 32'h0, 1'b0, "rpre");
    cycle(1'b1, 1'b0, 2'b11, 32'h8002_0100, 32'hB000_0000, 1'b0, 32'h0, 1'b1, "rburst0");
    for (int k = 1; k < 6; k++)
      cycle(1'b0, 1'b1, 2'b00, 32'h8002_0000, 32'hB000_0000 + 32'(k), 1'b0, 32'h0, 1'b1,
            $sformatf("rburst%0d", k));
    @(negedge clk);
    bus.enable = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("midreset.busy", {31'd0, bus.busy}, 32'd0);
    check("midreset.data", bus.data_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++)
      cycle(1'b1, 1'b1, 2'b00, 32'h8002_0100 + 32'(4 * k), 32'h0, 1'b1,
            (k < 6) ? 32'hB000_0000 + 32'(k) : 32'h5000_0000 + 32'(k), 1'b0,
            $sformatf("rback%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
